// File: rtl/alu_pkg.sv
// Shared ALU op codes, the multi-cycle ALU FSM state type and op-class helpers.
// Imported by alu_mc, alu_comb and the upstream ALU-op decoder.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } alu_state_t;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: add/sub/compare/logic; codes above SRA flag illegal with a zero result.
// Purely combinational, no backpressure; shift codes yield don't-care results handled by the caller.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  always_comb begin
    result  = '0;
    illegal = (op > OP_SRA);
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_XOR:  result = a ^ b;
      OP_OR:   result = a | b;
      OP_AND:  result = a & b;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I ALU: latency 1 for single-cycle ops, 1+shamt for shifts via a 1-bit/cycle shifter.
// Valid/ready on both sides; result held in DONE until taken, no accept in the handshake cycle.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [3:0]       i_alu_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  localparam int SW = $clog2(WIDTH);

  alu_state_t       state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SW-1:0]    cnt;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] comb_result;
  logic             comb_illegal;

  assign shamt = i_operand_b[SW-1:0];

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op      (i_alu_op),
    .a       (i_operand_a),
    .b       (i_operand_b),
    .result  (comb_result),
    .illegal (comb_illegal)
  );

  always_comb begin
    acc_next = {1'b0, acc[WIDTH-1:1]};
    if (op_q == OP_SLL) begin
      acc_next = {acc[WIDTH-2:0], 1'b0};
    end else if (op_q == OP_SRA) begin
      acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
    end
  end

  // o_ready/o_valid are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_result  <= '0;
      o_illegal <= 1'b0;
      op_q      <= OP_ADD;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_valid) begin
            op_q    <= i_alu_op;
            o_ready <= 1'b0;
            if (is_shift(i_alu_op) && (shamt != '0)) begin
              acc   <= i_operand_a;
              cnt   <= shamt;
              state <= ST_SHIFT;
            end else begin
              o_result  <= is_shift(i_alu_op) ? i_operand_a : comb_result;
              o_illegal <= is_shift(i_alu_op) ? 1'b0 : comb_illegal;
              o_valid   <= 1'b1;
              state     <= ST_DONE;
            end
          end
        end
        ST_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 1'b1;
          // The final shift lands straight in the result register as the counter hits zero.
          if (cnt == SW'(1)) begin
            o_result  <= acc_next;
            o_illegal <= 1'b0;
            o_valid   <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: begin
          state   <= ST_IDLE;
          o_valid <= 1'b0;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc: directed corner vectors, random ops, backpressure and mid-shift reset.
module tb_alu_mc;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [3:0]  i_alu_op = 4'd0;
  logic [31:0] i_operand_a = '0;
  logic [31:0] i_operand_b = '0;
  logic        o_ready;
  logic        o_valid;
  logic        o_illegal;
  logic [31:0] o_result;

  always #5 i_clk = ~i_clk;

  alu_mc #(.WIDTH(32)) dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_alu_op    (i_alu_op),
    .i_operand_a (i_operand_a),
    .i_operand_b (i_operand_b),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_result    (o_result),
    .o_illegal   (o_illegal)
  );

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    logic [4:0] sh;
    sh    = b[4:0];
    e.res = '0;
    e.ill = 1'b0;
    e.lat = 1;
    case (op)
      4'd0: e.res = a + b;
      4'd1: e.res = a - b;
      4'd2: e.res = {31'd0, ($signed(a) < $signed(b))};
      4'd3: e.res = {31'd0, (a < b)};
      4'd4: e.res = a ^ b;
      4'd5: e.res = a | b;
      4'd6: e.res = a & b;
      4'd7: begin e.res = a << sh; e.lat = 1 + int'(sh); end
      4'd8: begin e.res = a >> sh; e.lat = 1 + int'(sh); end
      4'd9: begin e.res = 32'($signed(a) >>> sh); e.lat = 1 + int'(sh); end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Drive one op at a falling edge; returns #1 after the accepting rising edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge i_clk);
    chk("ready_before_accept", {31'd0, o_ready}, 32'd1);
    i_valid     = 1'b1;
    i_alu_op    = op;
    i_operand_a = a;
    i_operand_b = b;
    sb.push_back(model(op, a, b));
    @(posedge i_clk);
    #1 i_valid = 1'b0;
  endtask

  // Wait for o_valid (latency counted in rising edges from accept), compare, then handshake.
  task automatic collect(input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (!o_valid && lat < 40) begin
      @(posedge i_clk);
      #1 lat++;
    end
    if (!o_valid) chk({tag, "_timeout"}, {31'd0, o_valid}, 32'd1);
    e = sb.pop_front();
    chk({tag, "_lat"}, 32'(lat), 32'(e.lat));
    chk({tag, "_res"}, o_result, e.res);
    chk({tag, "_ill"}, {31'd0, o_illegal}, {31'd0, e.ill});
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    chk({tag, "_ready_after"}, {31'd0, o_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] held;
    repeat (2) @(negedge i_clk);
    chk("rst_ready", {31'd0, o_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_result", o_result, 32'd0);
    chk("rst_illegal", {31'd0, o_illegal}, 32'd0);
    i_rst_n = 1'b1;

    issue(4'd1, 32'd5, 32'd7);                 collect("sub");
    issue(4'd2, 32'hFFFF_FFFF, 32'd1);         collect("slt");
    issue(4'd3, 32'hFFFF_FFFF, 32'd1);         collect("sltu");
    issue(4'd0, 32'hFFFF_FFFF, 32'd1);         collect("add_wrap");
    issue(4'd9, 32'h8000_0000, 32'h24);        collect("sra4");
    issue(4'd8, 32'h8000_0000, 32'h24);        collect("srl4");
    issue(4'd7, 32'd1, 32'd31);                collect("sll31");
    issue(4'd7, 32'hDEAD_BEEF, 32'd0);         collect("sll0");
    issue(4'd8, 32'h1234_5678, 32'h20);        collect("srl_b20");
    issue(4'd12, 32'h1234_5678, 32'h9);        collect("op12");
    issue(4'd4, 32'hF0F0_1234, 32'h0FF0_FFFF); collect("xor");
    issue(4'd5, 32'hF000_0001, 32'h0000_0F10); collect("or");
    issue(4'd6, 32'hF0F0_F0F0, 32'h3C3C_3C3C); collect("and");

    for (int i = 0; i < 16; i++) begin
      issue(4'($urandom_range(0, 15)), $urandom, $urandom);
      collect("rand");
    end

    // Backpressure: result held while a new op waits; it is taken only after the handshake.
    issue(4'd6, 32'hCAFE_F00D, 32'h0F0F_0F0F);
    @(posedge i_clk);
    #1 held = o_result;
    chk("bp_first_res", held, 32'hCAFE_F00D & 32'h0F0F_0F0F);
    i_valid = 1'b1; i_alu_op = 4'd0; i_operand_a = 32'd2; i_operand_b = 32'd3;
    for (int h = 0; h < 3; h++) begin
      @(posedge i_clk);
      #1;
      chk("bp_valid", {31'd0, o_valid}, 32'd1);
      chk("bp_result", o_result, held);
      chk("bp_ready", {31'd0, o_ready}, 32'd0);
    end
    void'(sb.pop_front());
    i_ready = 1'b1;
    @(posedge i_clk);
    #1 i_ready = 1'b0;
    chk("bp_hs_ready", {31'd0, o_ready}, 32'd1);
    chk("bp_hs_valid", {31'd0, o_valid}, 32'd0);
    sb.push_back(model(4'd0, 32'd2, 32'd3));
    @(posedge i_clk);
    #1 i_valid = 1'b0;
    collect("bp_next_add");

    // Asynchronous reset in the middle of a 10-step shift drops the op.
    issue(4'd7, 32'd1, 32'd10);
    repeat (3) @(posedge i_clk);
    #1 i_rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_result", o_result, 32'd0);
    chk("mid_rst_illegal", {31'd0, o_illegal}, 32'd0);
    sb.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1 chk("post_rst_ready", {31'd0, o_ready}, 32'd1);
    issue(4'd0, 32'd2, 32'd3);
    collect("post_rst_add");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
